// File: rtl/qspim_wb_arb_pkg.sv
// Shared types, constants and the rotating-priority pick function for the
// QSPI master Wishbone arbiter.
package qspim_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam int WB_BL_W = 10;
    localparam int MAX_NM  = 8;
    localparam int PTR_W   = 3;

    // One-hot winner: first asserted request after ptr, wrapping modulo nm.
    function automatic logic [MAX_NM-1:0] rr_pick(input logic [MAX_NM-1:0] req,
                                                  input logic [PTR_W-1:0]  ptr,
                                                  input int unsigned       nm);
        logic [MAX_NM-1:0] win;
        logic [PTR_W-1:0]  idx;
        win = '0;
        for (int unsigned i = 1; i <= 32'(MAX_NM); i++) begin
            idx = PTR_W'((32'(ptr) + i) % nm);
            if ((i <= nm) && (win == '0) && req[idx]) begin
                win[idx] = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/qspim_wb_arb_if.sv
// Bundle of the per-master request/response lanes and the single slave port.
interface qspim_wb_arb_if #(
    parameter int NM       = 3,
    parameter int WB_WIDTH = 32
);
    import qspim_arb_pkg::*;

    logic [NM-1:0]          m_stb_i;
    logic [NM*WB_WIDTH-1:0] m_adr_i;
    logic [NM-1:0]          m_we_i;
    logic [NM*WB_WIDTH-1:0] m_dat_i;
    logic [NM*4-1:0]        m_sel_i;
    logic [NM*WB_BL_W-1:0]  m_bl_i;
    logic [NM-1:0]          m_bry_i;
    logic [WB_WIDTH-1:0]    m_dat_o;
    logic [NM-1:0]          m_ack_o;
    logic [NM-1:0]          m_lack_o;
    logic [NM-1:0]          m_err_o;

    logic                   s_stb_o;
    logic [WB_WIDTH-1:0]    s_adr_o;
    logic                   s_we_o;
    logic [WB_WIDTH-1:0]    s_dat_o;
    logic [3:0]             s_sel_o;
    logic [WB_BL_W-1:0]     s_bl_o;
    logic                   s_bry_o;
    logic [WB_WIDTH-1:0]    s_dat_i;
    logic                   s_ack_i;
    logic                   s_lack_i;
    logic                   s_err_i;

    // Arbiter view: masters' requests in, slave port out.
    modport master (
        input  m_stb_i, m_adr_i, m_we_i, m_dat_i, m_sel_i, m_bl_i, m_bry_i,
        input  s_dat_i, s_ack_i, s_lack_i, s_err_i,
        output m_dat_o, m_ack_o, m_lack_o, m_err_o,
        output s_stb_o, s_adr_o, s_we_o, s_dat_o, s_sel_o, s_bl_o, s_bry_o
    );

    // Environment view: drives requests and slave responses.
    modport slave (
        output m_stb_i, m_adr_i, m_we_i, m_dat_i, m_sel_i, m_bl_i, m_bry_i,
        output s_dat_i, s_ack_i, s_lack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_lack_o, m_err_o,
        input  s_stb_o, s_adr_o, s_we_o, s_dat_o, s_sel_o, s_bl_o, s_bry_o
    );

endinterface

// File: rtl/qspim_wb_arb_rr_pick.sv
// Combinational one-hot priority picker; search starts just after ptr.
module qspim_rr_pick
    import qspim_arb_pkg::*;
#(
    parameter int NM = 3
) (
    input  logic [NM-1:0]    req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NM-1:0]    gnt,
    output logic [PTR_W-1:0] idx
);

    logic [MAX_NM-1:0] win_s;

    // Pick the winner and encode its index (win_s is one-hot, so OR is safe).
    always_comb begin
        win_s = rr_pick(MAX_NM'(req), ptr, NM);
        gnt   = win_s[NM-1:0];
        idx   = '0;
        for (int k = 0; k < NM; k++) begin
            idx = idx | ({PTR_W{win_s[k]}} & PTR_W'(k));
        end
    end

endmodule

// File: rtl/qspim_wb_arb.sv
// Burst-aware arbiter of NM Wishbone masters onto the QSPI master slave port,
// with a post-burst strobe gap and a stall watchdog.
module qspim_wb_arb
    import qspim_arb_pkg::*;
#(
    parameter int NM       = 3,
    parameter int WB_WIDTH = 32,
    parameter int TO_W     = 16
) (
    input  logic            mclk,
    input  logic            rst,
    qspim_wb_arb_if.master  bus,
    input  logic            cfg_arb_mode,
    input  logic [TO_W-1:0] cfg_timeout,
    output logic [NM-1:0]   grant_o,
    output logic            to_event_o
);

    arb_state_e        state_r;
    logic [NM-1:0]     grant_r;
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [TO_W-1:0]   wd_cnt_r;
    logic [TO_W-1:0]   to_lim_r;

    logic              busy_s;
    logic [NM-1:0]     gsel_s;
    logic              gstb_s;
    logic              wd_exp_s;
    logic              to_event_s;
    logic              exit_s;
    logic [NM-1:0]     win_s;
    logic [PTR_W-1:0]  win_idx_s;
    logic [PTR_W-1:0]  ptr_sel_s;

    // Fixed priority is a rotating search that always starts after NM-1.
    assign ptr_sel_s = cfg_arb_mode ? PTR_W'(NM - 1) : rr_ptr_r;

    qspim_rr_pick #(.NM(NM)) u_pick (
        .req (bus.m_stb_i),
        .ptr (ptr_sel_s),
        .gnt (win_s),
        .idx (win_idx_s)
    );

    assign busy_s     = (state_r == BUSY);
    assign gsel_s     = busy_s ? grant_r : '0;
    assign gstb_s     = |(gsel_s & bus.m_stb_i);
    assign wd_exp_s   = busy_s && (to_lim_r != '0) && !bus.s_ack_i &&
                        (wd_cnt_r == (to_lim_r - TO_W'(1)));
    // A simultaneous last-ack completes the burst normally.
    assign to_event_s = wd_exp_s && !bus.s_lack_i;
    assign exit_s     = busy_s && (bus.s_lack_i || bus.s_err_i || !gstb_s || wd_exp_s);

    assign grant_o    = grant_r;
    assign to_event_o = to_event_s;

    // Slave-side mux of the granted master plus response steering.
    always_comb begin
        bus.s_adr_o  = '0;
        bus.s_dat_o  = '0;
        bus.s_sel_o  = '0;
        bus.s_bl_o   = '0;
        bus.s_we_o   = |(gsel_s & bus.m_we_i);
        bus.s_bry_o  = |(gsel_s & bus.m_bry_i);
        bus.s_stb_o  = gstb_s;
        for (int k = 0; k < NM; k++) begin
            bus.s_adr_o = bus.s_adr_o | ({WB_WIDTH{gsel_s[k]}} & bus.m_adr_i[k*WB_WIDTH +: WB_WIDTH]);
            bus.s_dat_o = bus.s_dat_o | ({WB_WIDTH{gsel_s[k]}} & bus.m_dat_i[k*WB_WIDTH +: WB_WIDTH]);
            bus.s_sel_o = bus.s_sel_o | ({4{gsel_s[k]}} & bus.m_sel_i[k*4 +: 4]);
            bus.s_bl_o  = bus.s_bl_o  | ({WB_BL_W{gsel_s[k]}} & bus.m_bl_i[k*WB_BL_W +: WB_BL_W]);
        end
        bus.m_dat_o  = bus.s_dat_i;
        bus.m_ack_o  = gsel_s & {NM{bus.s_ack_i}};
        bus.m_lack_o = gsel_s & {NM{bus.s_lack_i || wd_exp_s}};
        bus.m_err_o  = gsel_s & {NM{bus.s_err_i || to_event_s}};
    end

    // Arbitration FSM, grant register, pointer and watchdog counter.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            rr_ptr_r <= PTR_W'(NM - 1);
            wd_cnt_r <= '0;
            to_lim_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|bus.m_stb_i) begin
                        grant_r  <= win_s;
                        rr_ptr_r <= win_idx_s;
                        wd_cnt_r <= '0;
                        to_lim_r <= cfg_timeout;
                        state_r  <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.s_ack_i) begin
                        wd_cnt_r <= '0;
                    end else if (wd_cnt_r != '1) begin
                        wd_cnt_r <= wd_cnt_r + TO_W'(1);
                    end
                    if (exit_s) begin
                        grant_r <= '0;
                        state_r <= GAP;
                    end
                end
                GAP: begin
                    grant_r <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    grant_r <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspim_wb_arb.sv
// Directed bench for qspim_wb_arb: reset, single burst, round-robin,
// fixed priority, watchdog, master abort and mid-burst reset.
module tb_qspim_wb_arb;

    localparam int NM = 3;
    localparam int W  = 32;
    localparam int TW = 16;

    logic          mclk = 1'b0;
    logic          rst;
    logic          cfg_arb_mode;
    logic [TW-1:0] cfg_timeout;
    logic [NM-1:0] grant_o;
    logic          to_event_o;

    int total = 0;
    int bad   = 0;

    qspim_wb_arb_if #(.NM(NM), .WB_WIDTH(W)) bus ();

    qspim_wb_arb #(.NM(NM), .WB_WIDTH(W), .TO_W(TW)) dut (
        .mclk         (mclk),
        .rst          (rst),
        .bus          (bus),
        .cfg_arb_mode (cfg_arb_mode),
        .cfg_timeout  (cfg_timeout),
        .grant_o      (grant_o),
        .to_event_o   (to_event_o)
    );

    always #5 mclk = ~mclk;

    task automatic adv();
        @(posedge mclk);
        #1;
    endtask

    task automatic smp();
        @(negedge mclk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] eg;
        rst          = 1'b1;
        cfg_arb_mode = 1'b0;
        cfg_timeout  = '0;
        bus.m_stb_i  = '0;
        bus.m_adr_i  = '0;
        bus.m_we_i   = '0;
        bus.m_dat_i  = '0;
        bus.m_sel_i  = '0;
        bus.m_bl_i   = '0;
        bus.m_bry_i  = '0;
        bus.s_dat_i  = '0;
        bus.s_ack_i  = 1'b0;
        bus.s_lack_i = 1'b0;
        bus.s_err_i  = 1'b0;
        adv();
        adv();
        smp();
        chk("rst_grant", grant_o, 3'b000);
        chk("rst_stb", bus.s_stb_o, 1'b0);
        chk("rst_ack", bus.m_ack_o, 3'b000);
        chk("rst_evt", to_event_o, 1'b0);
        rst = 1'b0;
        adv();

        // Single read burst from master 1, bl=4 at 0x100.
        bus.m_stb_i          = 3'b010;
        bus.m_adr_i[W +: W]  = 32'h0000_0100;
        bus.m_bl_i[10 +: 10] = 10'd4;
        bus.m_sel_i[4 +: 4]  = 4'hF;
        smp();
        chk("t1_latency", bus.s_stb_o, 1'b0);
        adv();
        for (int i = 0; i < 4; i++) begin
            bus.s_ack_i  = 1'b1;
            bus.s_lack_i = (i == 3);
            bus.s_dat_i  = 32'hA0 + 32'(i);
            smp();
            chk("t1_grant", grant_o, 3'b010);
            chk("t1_stb", bus.s_stb_o, 1'b1);
            chk("t1_adr", bus.s_adr_o, 32'h0000_0100);
            chk("t1_bl", bus.s_bl_o, 10'd4);
            chk("t1_sel", bus.s_sel_o, 4'hF);
            chk("t1_ack", bus.m_ack_o, 3'b010);
            chk("t1_lack", bus.m_lack_o, (i == 3) ? 3'b010 : 3'b000);
            chk("t1_dat", bus.m_dat_o, 32'hA0 + 32'(i));
            adv();
        end
        bus.s_ack_i  = 1'b0;
        bus.s_lack_i = 1'b0;
        bus.m_stb_i  = 3'b000;
        smp();
        chk("t1_gap_stb", bus.s_stb_o, 1'b0);
        chk("t1_gap_grant", grant_o, 3'b000);
        adv();
        smp();
        chk("t1_idle_grant", grant_o, 3'b000);

        // Round-robin from reset: order 0,1,2,0,1,2 with two dead cycles.
        rst = 1'b1;
        adv();
        rst = 1'b0;
        bus.m_stb_i = 3'b111;
        bus.m_bl_i  = {10'd1, 10'd1, 10'd1};
        smp();
        chk("t2_idle", grant_o, 3'b000);
        adv();
        for (int b = 0; b < 6; b++) begin
            eg = 3'b001 << (b % 3);
            bus.s_ack_i  = 1'b1;
            bus.s_lack_i = 1'b1;
            smp();
            chk("t2_grant", grant_o, eg);
            chk("t2_lack", bus.m_lack_o, eg);
            adv();
            bus.s_ack_i  = 1'b0;
            bus.s_lack_i = 1'b0;
            if (b == 5) bus.m_stb_i = 3'b000;
            smp();
            chk("t2_gap_grant", grant_o, 3'b000);
            chk("t2_gap_stb", bus.s_stb_o, 1'b0);
            adv();
            smp();
            chk("t2_dead_grant", grant_o, 3'b000);
            chk("t2_dead_stb", bus.s_stb_o, 1'b0);
            adv();
        end

        // Fixed priority: master 2 keeps its bl=8 burst while master 0 waits.
        cfg_arb_mode         = 1'b1;
        bus.m_stb_i          = 3'b100;
        bus.m_bl_i[20 +: 10] = 10'd8;
        adv();
        bus.m_stb_i = 3'b101;
        for (int i = 0; i < 8; i++) begin
            bus.s_ack_i  = 1'b1;
            bus.s_lack_i = (i == 7);
            smp();
            chk("t3_grant", grant_o, 3'b100);
            chk("t3_ack", bus.m_ack_o, 3'b100);
            adv();
        end
        bus.s_ack_i  = 1'b0;
        bus.s_lack_i = 1'b0;
        bus.m_stb_i  = 3'b001;
        adv();
        adv();
        bus.s_ack_i  = 1'b1;
        bus.s_lack_i = 1'b1;
        smp();
        chk("t3_next_grant", grant_o, 3'b001);
        chk("t3_next_lack", bus.m_lack_o, 3'b001);
        adv();
        bus.s_ack_i  = 1'b0;
        bus.s_lack_i = 1'b0;
        bus.m_stb_i  = 3'b000;
        adv();

        // Watchdog: timeout 16, slave never acks.
        cfg_timeout = 16'd16;
        bus.m_stb_i = 3'b001;
        adv();
        for (int c = 1; c <= 16; c++) begin
            smp();
            chk("t4_err", bus.m_err_o, (c == 16) ? 3'b001 : 3'b000);
            chk("t4_lack", bus.m_lack_o, (c == 16) ? 3'b001 : 3'b000);
            chk("t4_evt", to_event_o, (c == 16) ? 1'b1 : 1'b0);
            adv();
        end
        smp();
        chk("t4_gap_evt", to_event_o, 1'b0);
        chk("t4_gap_grant", grant_o, 3'b000);
        bus.m_stb_i = 3'b000;
        cfg_timeout = '0;
        adv();

        // Master 1 aborts after two acks; master 2 is served next.
        bus.m_stb_i = 3'b110;
        adv();
        for (int i = 0; i < 2; i++) begin
            bus.s_ack_i = 1'b1;
            smp();
            chk("t5_ack", bus.m_ack_o, 3'b010);
            adv();
        end
        bus.m_stb_i = 3'b100;
        smp();
        chk("t5_abort_stb", bus.s_stb_o, 1'b0);
        chk("t5_abort_ack", bus.m_ack_o, 3'b010);
        adv();
        smp();
        chk("t5_gap_ack", bus.m_ack_o, 3'b000);
        chk("t5_gap_grant", grant_o, 3'b000);
        bus.s_ack_i = 1'b0;
        adv();
        adv();
        bus.s_ack_i  = 1'b1;
        bus.s_lack_i = 1'b1;
        smp();
        chk("t5_next_grant", grant_o, 3'b100);
        chk("t5_next_lack", bus.m_lack_o, 3'b100);
        adv();
        bus.s_ack_i  = 1'b0;
        bus.s_lack_i = 1'b0;
        bus.m_stb_i  = 3'b000;
        adv();

        // Reset in the middle of a master-0 burst.
        bus.m_stb_i = 3'b001;
        adv();
        bus.s_ack_i = 1'b1;
        smp();
        chk("t6_pre_ack", bus.m_ack_o, 3'b001);
        rst = 1'b1;
        adv();
        smp();
        chk("t6_grant", grant_o, 3'b000);
        chk("t6_stb", bus.s_stb_o, 1'b0);
        chk("t6_ack", bus.m_ack_o, 3'b000);
        chk("t6_evt", to_event_o, 1'b0);
        rst          = 1'b0;
        bus.s_ack_i  = 1'b0;
        cfg_arb_mode = 1'b0;
        bus.m_stb_i  = 3'b011;
        adv();
        bus.s_ack_i  = 1'b1;
        bus.s_lack_i = 1'b1;
        smp();
        chk("t6_rr_ptr", grant_o, 3'b001);
        chk("t6_lack", bus.m_lack_o, 3'b001);
        adv();
        bus.s_ack_i  = 1'b0;
        bus.s_lack_i = 1'b0;
        bus.m_stb_i  = 3'b000;
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
